// File: rtl/imm_pkg.sv
// Shared types for the pipelined RISC-V immediate generator.
// Opcode encodings, the immediate-format enum and the per-lane decode record.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Every RV immediate fits in 32 bits; widening to XLEN happens at the lane output.
  typedef struct packed {
    logic [31:0] imm;
    imm_type_e   imm_type;
    logic        illegal;
  } imm_lane_t;

  function automatic logic is_known_opcode(input logic [6:0] opc);
    return (opc == OPC_OP_IMM) || (opc == OPC_LOAD)   || (opc == OPC_JALR) ||
           (opc == OPC_STORE)  || (opc == OPC_BRANCH) || (opc == OPC_LUI)  ||
           (opc == OPC_AUIPC)  || (opc == OPC_JAL);
  endfunction

endpackage

// File: rtl/imm_decode_lane.sv
// Combinational single-lane immediate decoder.
// Produces the sign-extended immediate, its format and an unknown-opcode flag.
module imm_decode_lane
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_vld,
  input  logic [31:0]     i_insn,
  output logic [XLEN-1:0] o_imm,
  output logic [2:0]      o_imm_type,
  output logic            o_illegal
);

  imm_lane_t  w_dec;
  logic [6:0] w_opc;

  assign w_opc = i_insn[6:0];

  always_comb begin
    w_dec          = '0;
    w_dec.imm_type = IMM_NONE;
    if (i_vld) begin
      case (w_opc)
        OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
          w_dec.imm      = {{20{i_insn[31]}}, i_insn[31:20]};
          w_dec.imm_type = IMM_I;
        end
        OPC_STORE: begin
          w_dec.imm      = {{20{i_insn[31]}}, i_insn[31:25], i_insn[11:7]};
          w_dec.imm_type = IMM_S;
        end
        OPC_BRANCH: begin
          w_dec.imm      = {{19{i_insn[31]}}, i_insn[31], i_insn[7],
                            i_insn[30:25], i_insn[11:8], 1'b0};
          w_dec.imm_type = IMM_B;
        end
        OPC_LUI, OPC_AUIPC: begin
          w_dec.imm      = {i_insn[31:12], 12'b0};
          w_dec.imm_type = IMM_U;
        end
        OPC_JAL: begin
          w_dec.imm      = {{11{i_insn[31]}}, i_insn[31], i_insn[19:12],
                            i_insn[20], i_insn[30:21], 1'b0};
          w_dec.imm_type = IMM_J;
        end
        default: begin
          w_dec.illegal  = ~is_known_opcode(w_opc);
        end
      endcase
    end
  end

  // Signed size cast sign-extends from bit 31 when XLEN is 64.
  assign o_imm      = XLEN'($signed(w_dec.imm));
  assign o_imm_type = w_dec.imm_type;
  assign o_illegal  = w_dec.illegal;

endmodule

// File: rtl/imm_gen_pipe.sv
// Multi-lane immediate generator: per-lane decode feeding a 2-entry registered skid buffer.
// Outputs are taken directly from the head entry; popped or flushed entries are cleared.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [LANES-1:0]      in_lane_vld_i,
  input  logic [LANES*32-1:0]   in_insn_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES-1:0]      out_lane_vld_o,
  output logic [LANES*XLEN-1:0] out_imm_o,
  output logic [LANES*3-1:0]    out_imm_type_o,
  output logic [LANES-1:0]      out_illegal_o
);

  logic [LANES*XLEN-1:0] w_dec_imm;
  logic [LANES*3-1:0]    w_dec_type;
  logic [LANES-1:0]      w_dec_ill;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    imm_decode_lane #(
      .XLEN (XLEN)
    ) u_dec (
      .i_vld      (in_lane_vld_i[gi]),
      .i_insn     (in_insn_i[gi*32 +: 32]),
      .o_imm      (w_dec_imm[gi*XLEN +: XLEN]),
      .o_imm_type (w_dec_type[gi*3 +: 3]),
      .o_illegal  (w_dec_ill[gi])
    );
  end

  logic [1:0]            r_count;
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [LANES-1:0]      r_lane_vld [2];
  logic [LANES*XLEN-1:0] r_imm      [2];
  logic [LANES*3-1:0]    r_type     [2];
  logic [LANES-1:0]      r_ill      [2];

  logic w_push;
  logic w_pop;
  logic w_store;

  assign in_ready_o  = (r_count != 2'd2);
  assign out_valid_o = (r_count != 2'd0);
  assign w_push      = in_valid_i & in_ready_o;
  assign w_pop       = out_valid_o & out_ready_i;
  // Beats with no valid lane complete the handshake but occupy no entry.
  assign w_store     = w_push & (|in_lane_vld_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else if (flush_i) begin
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_store) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)   r_rd_ptr <= ~r_rd_ptr;
    end
  end

  // Popped entries are zeroed so an empty buffer presents reset-valued outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < 2; e++) begin
        r_lane_vld[e] <= '0;
        r_imm[e]      <= '0;
        r_type[e]     <= '0;
        r_ill[e]      <= '0;
      end
    end else if (flush_i) begin
      for (int e = 0; e < 2; e++) begin
        r_lane_vld[e] <= '0;
        r_imm[e]      <= '0;
        r_type[e]     <= '0;
        r_ill[e]      <= '0;
      end
    end else begin
      for (int e = 0; e < 2; e++) begin
        if (w_pop && (r_rd_ptr == 1'(e))) begin
          r_lane_vld[e] <= '0;
          r_imm[e]      <= '0;
          r_type[e]     <= '0;
          r_ill[e]      <= '0;
        end
        if (w_store && (r_wr_ptr == 1'(e))) begin
          r_lane_vld[e] <= in_lane_vld_i;
          r_imm[e]      <= w_dec_imm;
          r_type[e]     <= w_dec_type;
          r_ill[e]      <= w_dec_ill;
        end
      end
    end
  end

  assign out_lane_vld_o = r_lane_vld[r_rd_ptr];
  assign out_imm_o      = r_imm[r_rd_ptr];
  assign out_imm_type_o = r_type[r_rd_ptr];
  assign out_illegal_o  = r_ill[r_rd_ptr];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (LANES=2, with XLEN=32 and XLEN=64 instances).
module tb_imm_gen_pipe;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush_i;
  logic         in_valid_i;
  logic [1:0]   in_lane_vld_i;
  logic [63:0]  in_insn_i;
  logic         out_ready_i;

  logic         in_ready_o,     in_ready64;
  logic         out_valid_o,    out_valid64;
  logic [1:0]   out_lane_vld_o, out_lane_vld64;
  logic [63:0]  out_imm_o;
  logic [127:0] out_imm64;
  logic [5:0]   out_imm_type_o, out_imm_type64;
  logic [1:0]   out_illegal_o,  out_illegal64;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.LANES(2), .XLEN(32)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_lane_vld_i  (in_lane_vld_i),
    .in_insn_i      (in_insn_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_lane_vld_o (out_lane_vld_o),
    .out_imm_o      (out_imm_o),
    .out_imm_type_o (out_imm_type_o),
    .out_illegal_o  (out_illegal_o)
  );

  imm_gen_pipe #(.LANES(2), .XLEN(64)) u_dut64 (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready64),
    .in_lane_vld_i  (in_lane_vld_i),
    .in_insn_i      (in_insn_i),
    .out_valid_o    (out_valid64),
    .out_ready_i    (out_ready_i),
    .out_lane_vld_o (out_lane_vld64),
    .out_imm_o      (out_imm64),
    .out_imm_type_o (out_imm_type64),
    .out_illegal_o  (out_illegal64)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("[TB] %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    flush_i       = 1'b0;
    in_valid_i    = 1'b0;
    in_lane_vld_i = 2'b00;
    in_insn_i     = '0;
    out_ready_i   = 1'b0;
    step();
    step();
    check("rst_out_valid", 128'(out_valid_o), 128'(1'b0));
    check("rst_lane_vld",  128'(out_lane_vld_o), 128'(2'b00));
    check("rst_imm",       128'(out_imm_o), 128'(64'h0));
    check("rst_type",      128'(out_imm_type_o), 128'({T_NONE, T_NONE}));
    check("rst_illegal",   128'(out_illegal_o), 128'(2'b00));
    rst_n = 1'b1;
    #1;
    check("rst_in_ready",  128'(in_ready_o), 128'(1'b1));

    // ADDI -1 lane0, BEQ -4 lane1
    in_valid_i = 1'b1; in_lane_vld_i = 2'b11; out_ready_i = 1'b1;
    in_insn_i  = {32'hFE000EE3, 32'hFFF00093};
    step();
    in_valid_i = 1'b0;
    check("ib_valid",   128'(out_valid_o), 128'(1'b1));
    check("ib_imm",     128'(out_imm_o), 128'({32'hFFFFFFFC, 32'hFFFFFFFF}));
    check("ib_type",    128'(out_imm_type_o), 128'({T_B, T_I}));
    check("ib_illegal", 128'(out_illegal_o), 128'(2'b00));
    step();
    check("ib_popped",  128'(out_valid_o), 128'(1'b0));

    // LUI 0x80000 lane0, JAL -8 lane1, both widths
    in_valid_i = 1'b1; in_lane_vld_i = 2'b11;
    in_insn_i  = {32'hFF9FF06F, 32'h800000B7};
    step();
    in_valid_i = 1'b0;
    check("uj64_imm",  out_imm64, {64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFF80000000});
    check("uj64_type", 128'(out_imm_type64), 128'({T_J, T_U}));
    check("uj32_imm",  128'(out_imm_o), 128'({32'hFFFFFFF8, 32'h80000000}));
    step();

    // Unknown opcode lane0, lane1 invalid (carrying a legal ADDI)
    in_valid_i = 1'b1; in_lane_vld_i = 2'b01;
    in_insn_i  = {32'h00500093, 32'h0000007F};
    step();
    in_valid_i = 1'b0;
    check("ill_illegal",  128'(out_illegal_o), 128'(2'b01));
    check("ill_imm",      128'(out_imm_o), 128'(64'h0));
    check("ill_type",     128'(out_imm_type_o), 128'({T_NONE, T_NONE}));
    check("ill_lane_vld", 128'(out_lane_vld_o), 128'(2'b01));
    step();

    // Beat with no valid lane is accepted but not stored
    in_valid_i = 1'b1; in_lane_vld_i = 2'b00; in_insn_i = {32'h00100093, 32'h00100093};
    step();
    in_valid_i = 1'b0;
    check("empty_beat", 128'(out_valid_o), 128'(1'b0));

    // Backpressure: A, B fill the buffer, C is held until space frees
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_lane_vld_i = 2'b01; in_insn_i = {32'h0, 32'h00100093};
    step();
    in_insn_i = {32'h0, 32'h00200093};
    step();
    check("bp_ready_full", 128'(in_ready_o), 128'(1'b0));
    check("bp_head_A",     128'(out_imm_o), 128'(64'h1));
    in_insn_i = {32'h0, 32'h00300093};
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_head", 128'(out_imm_o), 128'(64'h1));
    end
    check("bp_hold_ready", 128'(in_ready_o), 128'(1'b0));
    out_ready_i = 1'b1;
    step();
    check("bp_head_B",  128'(out_imm_o), 128'(64'h2));
    check("bp_ready_1", 128'(in_ready_o), 128'(1'b1));
    step();
    in_valid_i = 1'b0;
    check("bp_head_C",  128'(out_imm_o), 128'(64'h3));
    check("bp_valid_C", 128'(out_valid_o), 128'(1'b1));
    step();
    check("bp_drained", 128'(out_valid_o), 128'(1'b0));

    // Flush with a full buffer and a pending push
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_lane_vld_i = 2'b01; in_insn_i = {32'h0, 32'h00400093};
    step();
    in_insn_i = {32'h0, 32'h00500093};
    step();
    check("fl_full", 128'(in_ready_o), 128'(1'b0));
    flush_i = 1'b1; in_insn_i = {32'h0, 32'h00600093};
    step();
    flush_i = 1'b0; in_valid_i = 1'b0;
    check("fl_valid", 128'(out_valid_o), 128'(1'b0));
    check("fl_ready", 128'(in_ready_o), 128'(1'b1));
    check("fl_imm",   128'(out_imm_o), 128'(64'h0));
    out_ready_i = 1'b1;
    step();
    check("fl_no_ghost", 128'(out_valid_o), 128'(1'b0));

    // Asynchronous reset with one beat buffered
    out_ready_i = 1'b0;
    in_valid_i = 1'b1; in_lane_vld_i = 2'b01; in_insn_i = {32'h0, 32'h00700093};
    step();
    in_valid_i = 1'b0;
    check("ar_pre_valid", 128'(out_valid_o), 128'(1'b1));
    #3 rst_n = 1'b0;
    #1;
    check("ar_valid_drop", 128'(out_valid_o), 128'(1'b0));
    check("ar_imm_clear",  128'(out_imm_o), 128'(64'h0));
    #2 rst_n = 1'b1;
    in_valid_i = 1'b1; in_insn_i = {32'h0, 32'h00800093};
    step();
    in_valid_i = 1'b0;
    check("ar_post_valid", 128'(out_valid_o), 128'(1'b1));
    check("ar_post_imm",   128'(out_imm_o), 128'(64'h8));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
